// File: rtl/fpga_cfg_loader_pkg.sv
// fpga_cfg_pkg: shared constants, FSM state encoding and the CRC-8 byte step
// for the fabric configuration loader.
// Optional feature macro: FPGA_CFG_CRC_EN (adds the CRC state).
package fpga_cfg_pkg;

    localparam int BYTE_W    = 8;
    localparam int IMG_BITS  = 2828;
    localparam int IMG_BYTES = 354;
    localparam int CNT_W     = 9;     // byte index 0..353

    // Per-vector widths
    localparam int BRB_W = 900;
    localparam int BSB_W = 1728;
    localparam int LB_W  = 80;
    localparam int IO_W  = 30;

    // Base offsets of each vector inside the image
    localparam int BRB_OFS = 0;
    localparam int BSB_OFS = 900;
    localparam int LB_OFS  = 2628;
    localparam int LIO_OFS = 2708;
    localparam int RIO_OFS = 2738;
    localparam int TIO_OFS = 2768;
    localparam int BIO_OFS = 2798;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
`ifdef FPGA_CFG_CRC_EN
        , ST_CRC  = 2'd3
`endif
    } state_t;

    // CRC-8, poly 0x07, MSB first, one byte folded in
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Byte-stream valid/ready channel feeding the configuration loader.
interface fpga_cfg_loader_if;
    import fpga_cfg_pkg::*;

    logic              cfg_valid;
    logic [BYTE_W-1:0] cfg_data;
    logic              cfg_ready;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);

endinterface

// File: rtl/fpga_cfg_crc8.sv
// Running CRC-8 (poly 0x07, init 0x00) over the accepted image bytes.
module fpga_cfg_crc8
    import fpga_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    // CRC register: cleared at the start of each load, folds in every accepted byte
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_byte(crc, data);
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: assembles a configuration image from a byte stream into a
// shadow register and commits all seven fabric vectors in one edge, so the
// fabric never sees a partially loaded image.
// Optional feature macro: FPGA_CFG_CRC_EN (trailing CRC-8 byte check, cfg_err).
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int BYTE_W    = 8,
    parameter int IMG_BITS  = 2828,
    parameter int IMG_BYTES = 354
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    fpga_cfg_loader_if.slave    cfg,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic [BRB_W-1:0]    brbselect,
    output logic [BSB_W-1:0]    bsbselect,
    output logic [LB_W-1:0]     lbselect,
    output logic [IO_W-1:0]     leftioselect,
    output logic [IO_W-1:0]     rightioselect,
    output logic [IO_W-1:0]     topioselect,
    output logic [IO_W-1:0]     bottomioselect
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [IMG_BITS-1:0] shadow_q;
    logic                begin_load;
    logic                load_acc;
    logic                last_byte;
    logic                abort_hit;

    assign begin_load = (state_q == ST_IDLE) && start;
    // abort wins over a byte offered in the same cycle
    assign load_acc   = (state_q == ST_LOAD) && cfg.cfg_valid && !abort;
    assign last_byte  = (cnt_q == CNT_W'(IMG_BYTES - 1));

`ifdef FPGA_CFG_CRC_EN
    logic [7:0] crc_q;
    logic       crc_ok;
    logic       crc_acc;

    assign abort_hit = abort && ((state_q == ST_LOAD) || (state_q == ST_CRC));
    assign crc_acc   = (state_q == ST_CRC) && cfg.cfg_valid && !abort;
    assign crc_ok    = (cfg.cfg_data == crc_q);

    fpga_cfg_crc8 u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (begin_load),
        .en   (load_acc),
        .data (cfg.cfg_data),
        .crc  (crc_q)
    );

    // Sticky error: set by a bad CRC byte, cleared by the next start
    always_ff @(posedge clk) begin
        if (rst || begin_load) begin
            cfg_err <= 1'b0;
        end else if (crc_acc && !crc_ok) begin
            cfg_err <= 1'b1;
        end
    end
`else
    assign abort_hit = abort && (state_q == ST_LOAD);
    assign cfg_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode; ready/busy depend only on the registered state
    always_comb begin
        state_d       = state_q;
        cfg.cfg_ready = 1'b0;
        cfg_busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cfg.cfg_ready = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cfg.cfg_valid && last_byte) begin
`ifdef FPGA_CFG_CRC_EN
                    state_d = ST_CRC;
`else
                    state_d = ST_COMMIT;
`endif
                end
            end
`ifdef FPGA_CFG_CRC_EN
            ST_CRC: begin
                cfg.cfg_ready = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cfg.cfg_valid) begin
                    state_d = crc_ok ? ST_COMMIT : ST_IDLE;
                end
            end
`endif
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte counter: index of the next image byte
    always_ff @(posedge clk) begin
        if (rst || begin_load) begin
            cnt_q <= '0;
        end else if (load_acc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Shadow image: byte k lands in bits 8k+7..8k; bits past IMG_BITS are dropped
    always_ff @(posedge clk) begin
        if (rst || begin_load || abort_hit) begin
            shadow_q <= '0;
        end else if (load_acc) begin
            for (int i = 0; i < BYTE_W; i++) begin
                if ({cnt_q, 3'(i)} < 12'(IMG_BITS)) begin
                    shadow_q[{cnt_q, 3'(i)}] <= cfg.cfg_data[3'(i)];
                end
            end
        end
    end

    // Committed configuration: all vectors update together on the COMMIT edge
    always_ff @(posedge clk) begin
        if (rst) begin
            brbselect      <= '0;
            bsbselect      <= '0;
            lbselect       <= '0;
            leftioselect   <= '0;
            rightioselect  <= '0;
            topioselect    <= '0;
            bottomioselect <= '0;
        end else if (state_q == ST_COMMIT) begin
            brbselect      <= shadow_q[BRB_OFS +: BRB_W];
            bsbselect      <= shadow_q[BSB_OFS +: BSB_W];
            lbselect       <= shadow_q[LB_OFS  +: LB_W];
            leftioselect   <= shadow_q[LIO_OFS +: IO_W];
            rightioselect  <= shadow_q[RIO_OFS +: IO_W];
            topioselect    <= shadow_q[TIO_OFS +: IO_W];
            bottomioselect <= shadow_q[BIO_OFS +: IO_W];
        end
    end

    // Done pulse: the cycle after COMMIT, when the new image is visible
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= (state_q == ST_COMMIT);
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Testbench for fpga_cfg_loader: directed streams checked every cycle against
// a transaction-level model, plus literal expectations on key results.
// Optional feature macro: FPGA_CFG_CRC_EN (adds the CRC scenarios).
module tb_fpga_cfg_loader;
    import fpga_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic cfg_busy, cfg_done, cfg_err;
    logic [BRB_W-1:0] brbselect;
    logic [BSB_W-1:0] bsbselect;
    logic [LB_W-1:0]  lbselect;
    logic [IO_W-1:0]  leftioselect, rightioselect, topioselect, bottomioselect;
    logic [IMG_BITS-1:0] dut_flat;

    fpga_cfg_loader_if bus ();

    fpga_cfg_loader dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg            (bus),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err),
        .brbselect      (brbselect),
        .bsbselect      (bsbselect),
        .lbselect       (lbselect),
        .leftioselect   (leftioselect),
        .rightioselect  (rightioselect),
        .topioselect    (topioselect),
        .bottomioselect (bottomioselect)
    );

    always #5 clk = ~clk;

    // Image view of the outputs, lowest offset first
    assign dut_flat = {bottomioselect, topioselect, rightioselect, leftioselect,
                       lbselect, bsbselect, brbselect};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_acc = -1;
    bit chk_en   = 1'b0;

    // Model state: loading / awaiting crc / commit pending, plus received bytes
    bit m_loading = 0, m_crcph = 0, m_pend = 0, m_done = 0, m_err = 0;
    int m_cnt = 0;
    logic [7:0] m_img [IMG_BYTES];
    logic [IMG_BITS-1:0] m_cfg = '0;

    function automatic logic [IMG_BITS-1:0] flatten();
        logic [IMG_BITS-1:0] r;
        for (int b = 0; b < IMG_BITS; b++) r[b] = m_img[b / 8][b % 8];
        return r;
    endfunction

    // Bit-serial CRC-8 over the received image bytes
    function automatic logic [7:0] model_crc();
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int k = 0; k < IMG_BYTES; k++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ m_img[k][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Model update from the inputs seen at each rising edge
    always @(posedge clk) begin : model
        bit was_idle;
        cyc++;
        if (rst) begin
            m_loading = 0; m_crcph = 0; m_pend = 0; m_done = 0; m_err = 0;
            m_cnt = 0; m_cfg = '0;
        end else begin
            m_done   = 0;
            was_idle = !m_loading && !m_crcph && !m_pend;
            if (m_pend) begin
                m_cfg  = flatten();
                m_done = 1;
                m_pend = 0;
            end else if (was_idle) begin
                if (start) begin
                    m_loading = 1; m_cnt = 0; m_err = 0;
                    for (int k = 0; k < IMG_BYTES; k++) m_img[k] = 8'h00;
                end
            end else if (m_loading) begin
                if (abort) begin
                    m_loading = 0;
                end else if (bus.cfg_valid) begin
                    m_img[m_cnt] = bus.cfg_data;
                    m_cnt++;
                    if (m_cnt == IMG_BYTES) begin
                        m_loading = 0;
`ifdef FPGA_CFG_CRC_EN
                        m_crcph = 1;
`else
                        m_pend = 1;
`endif
                    end
                end
            end else if (m_crcph) begin
                if (abort) begin
                    m_crcph = 0;
                end else if (bus.cfg_valid) begin
                    m_crcph = 0;
                    if (bus.cfg_data == model_crc()) m_pend = 1;
                    else m_err = 1;
                end
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkv(input string name, input logic [IMG_BITS-1:0] act,
                        input logic [IMG_BITS-1:0] exp);
        int first;
        checks++;
        if (act !== exp) begin
            failures++;
            first = -1;
            for (int b = 0; b < IMG_BITS; b++)
                if (first < 0 && act[b] !== exp[b]) first = b;
            $display("FAIL %s: ones got %0d required %0d, first bad bit %0d (cycle %0d)",
                     name, $countones(act), $countones(exp), first, cyc);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("cfg_ready", bus.cfg_ready, m_loading || m_crcph);
            chk1("cfg_busy", cfg_busy, m_loading || m_crcph || m_pend);
            chk1("cfg_done", cfg_done, m_done);
            chk1("cfg_err", cfg_err, m_err);
            chkv("cfg_image", dut_flat, m_cfg);
            if (cfg_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [7:0] byte_val(input int mode, input int k, input logic [7:0] v);
        case (mode)
            0:       return v;
            1:       return (k == 0) ? 8'h21 : ((k == 349) ? 8'h40 : 8'h00);
            default: return 8'((k * 37) + int'(v));
        endcase
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer bytes until n are accepted (optionally every other cycle)
    task automatic send(input int n, input int mode, input logic [7:0] v,
                        input bit bubbles, output int cycles);
        int  k;
        bit  ph;
        bit  acc;
        k = 0; ph = 1'b1; cycles = 0;
        while (k < n) begin
            bus.cfg_valid = bubbles ? ph : 1'b1;
            bus.cfg_data  = byte_val(mode, k, v);
            acc = bus.cfg_valid && (bus.cfg_ready === 1'b1);
            if (acc) last_acc = cyc + 1;
            @(negedge clk);
            if (acc) k++;
            cycles++;
            ph = ~ph;
            if (cycles > 2000) begin
                checks++; failures++;
                $display("FAIL send_timeout: accepted %0d required %0d", k, n);
                break;
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    // Full image, followed by the matching CRC byte in the CRC build
    task automatic send_image(input int mode, input logic [7:0] v, input bit bubbles,
                              output int cycles);
        send(IMG_BYTES, mode, v, bubbles, cycles);
`ifdef FPGA_CFG_CRC_EN
        begin
            int c2;
            send(1, 0, model_crc(), 1'b0, c2);
        end
`endif
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (cfg_done !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cfg_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: cfg_done got %b required 1", name, cfg_done);
        end else begin
            chkint({name, "_latency"}, cyc - last_acc, 1);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cycles;
        int dc;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk1("rst_busy", cfg_busy, 1'b0);
        chk1("rst_ready", bus.cfg_ready, 1'b0);
        chk1("rst_done", cfg_done, 1'b0);
        chkv("rst_image", dut_flat, '0);
        rst = 1'b0;
        @(negedge clk);

        // Full load of the sparse test image
        pulse_start();
        send_image(1, 8'h00, 1'b0, cycles);
        wait_done("full");
        chk1("full_brb0", brbselect[0], 1'b1);
        chk1("full_brb5", brbselect[5], 1'b1);
        chk1("full_bio0", bottomioselect[0], 1'b1);
        chkint("full_ones", $countones(dut_flat), 3);
        @(negedge clk);

        // Reset in the middle of a load
        pulse_start();
        send(100, 0, 8'hFF, 1'b0, cycles);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk1("midrst_busy", cfg_busy, 1'b0);
        chk1("midrst_ready", bus.cfg_ready, 1'b0);
        chkv("midrst_image", dut_flat, '0);
        rst = 1'b0;
        @(negedge clk);

        // Reload from byte 0 after reset
        pulse_start();
        send_image(1, 8'h00, 1'b0, cycles);
        wait_done("reload");
        chk1("reload_brb5", brbselect[5], 1'b1);
        chkint("reload_ones", $countones(dut_flat), 3);
        @(negedge clk);

        // Bubbles: 0xFF every other cycle, last accept on cycle 707 of 708
        pulse_start();
        send(IMG_BYTES, 0, 8'hFF, 1'b1, cycles);
        chkint("bubble_cycles", cycles, 2 * IMG_BYTES - 1);
        chkint("bubble_hold_ones", $countones(dut_flat), 3);
`ifdef FPGA_CFG_CRC_EN
        send(1, 0, model_crc(), 1'b0, dc);
`endif
        wait_done("bubble");
        chkv("bubble_image", dut_flat, {IMG_BITS{1'b1}});
        @(negedge clk);

        // Abort on byte 200, with an ignored start mid-load
        dc = done_cnt;
        pulse_start();
        send(50, 2, 8'h11, 1'b0, cycles);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(150, 2, 8'h11, 1'b0, cycles);
        bus.cfg_valid = 1'b1; bus.cfg_data = 8'h00; abort = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0; abort = 1'b0;
        chk1("abort_busy", cfg_busy, 1'b0);
        chkv("abort_image", dut_flat, {IMG_BITS{1'b1}});
        repeat (3) @(negedge clk);
        chkint("abort_no_done", done_cnt, dc);

        // Back-to-back loads: second start in the cfg_done cycle
        pulse_start();
        send_image(2, 8'h03, 1'b0, cycles);
        wait_done("b2b_a");
        pulse_start();
        send_image(2, 8'd200, 1'b0, cycles);
        wait_done("b2b_b");
        chkint("b2b_byte0", int'(brbselect[7:0]), 8'hC8);
        chkint("b2b_byte1", int'(brbselect[15:8]), 8'hED);
        @(negedge clk);

`ifdef FPGA_CFG_CRC_EN
        // CRC: zero image with 0x00 commits
        pulse_start();
        send(IMG_BYTES, 0, 8'h00, 1'b0, cycles);
        send(1, 0, 8'h00, 1'b0, cycles);
        wait_done("crc_ok");
        chkv("crc_ok_image", dut_flat, '0);
        chk1("crc_ok_err", cfg_err, 1'b0);
        @(negedge clk);

        // CRC mismatch: error, no commit
        dc = done_cnt;
        pulse_start();
        send(IMG_BYTES, 0, 8'h00, 1'b0, cycles);
        send(1, 0, 8'h01, 1'b0, cycles);
        chk1("crc_bad_err", cfg_err, 1'b1);
        chk1("crc_bad_busy", cfg_busy, 1'b0);
        repeat (3) @(negedge clk);
        chkint("crc_bad_no_done", done_cnt, dc);
        chkv("crc_bad_image", dut_flat, '0);

        // Next start clears the error
        pulse_start();
        chk1("crc_err_clear", cfg_err, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

- Loads the fabric configuration of `fpga_top` from a byte stream with a valid/ready handshake.
- Assembles the stream in a shadow register and drives the seven configuration vectors atomically once a complete image has arrived: `brbselect`, `bsbselect`, `lbselect`, and the four io selects.
- Sits directly upstream of `fpga_top` and replaces direct poking of configuration bits.

## Interface
Parameters:
- `BYTE_W`, 8, stream byte width (fixed; not to be overridden)
- `IMG_BITS`, 2828, total configuration bits (900+1728+80+4·30)
- `IMG_BYTES`, 354, ceil(IMG_BITS/8)

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle request to begin loading an image.
- `abort` in 1: cancels a load in progress.
- `cfg_valid` in 1: byte-stream valid.
- `cfg_data` in 8: byte-stream data.
- `cfg_ready` out 1: loader accepts a byte.
- `cfg_busy` out 1: high in any state other than IDLE.
- `cfg_done` out 1: one-cycle pulse when an image is committed.
- `cfg_err` out 1: sticky error flag (CRC build only).
- `brbselect` out 900, `bsbselect` out 1728, `lbselect` out 80: fabric configuration vectors.
- `leftioselect`, `rightioselect`, `topioselect`, `bottomioselect` out 30 each: io configuration vectors.

## Operation
- States: IDLE, LOAD, CRC (CRC build only), COMMIT.
- **IDLE → LOAD:** on `start`.
  - Byte counter cleared; shadow cleared; `cfg_err` cleared.
  - `start` is ignored in every state except IDLE.
- **LOAD:**
  - `cfg_ready`=1; a byte is accepted when `cfg_valid`&`cfg_ready`.
  - Byte k is written to shadow[8k+7:8k], LSB of the image first.
  - Shadow bits 2831:2828 (upper nibble of byte 353) are discarded.
  - After byte 353 is accepted: go to COMMIT, or to CRC in the CRC build.
- **COMMIT:** `cfg_ready`=0. Outputs load from the shadow, `cfg_done` pulses, state returns to IDLE. Shadow slices:
  - `brbselect` = [899:0]
  - `bsbselect` = [2627:900]
  - `lbselect` = [2707:2628]
  - `leftioselect` = [2737:2708]
  - `rightioselect` = [2767:2738]
  - `topioselect` = [2797:2768]
  - `bottomioselect` = [2827:2798]
- **`abort`** in LOAD or CRC → IDLE on the next edge.
  - Shadow is discarded.
  - Outputs keep their previously committed image.
  - No `cfg_done` pulse.
  - `abort` has priority over a byte accept in the same cycle.
- **Outputs during a load:** they hold the last committed image, so `fpga_top` never sees a partial configuration.
- **`rst` at any time, including mid-load:**
  - State → IDLE, counter 0.
  - Shadow and all configuration outputs → 0.
  - `cfg_ready`, `cfg_busy`, `cfg_done`, `cfg_err` → 0.

## Timing
- `cfg_ready` and `cfg_busy` are decoded from the registered state, with no combinational path from `cfg_valid`.
- `start` sampled at edge S: `cfg_ready` is high from the cycle after S.
- Throughput: one byte per cycle when `cfg_valid` is held high. A full image takes 354 accepting cycles.
- Final byte accepted at edge N:
  - state is COMMIT in cycle N..N+1;
  - outputs change at edge N+1;
  - `cfg_done` is high for exactly cycle N+1..N+2.
- Back-to-back loads: `start` is honoured in the cycle `cfg_done` is high, because the state is already IDLE.

## Configuration
- Macro: `FPGA_CFG_CRC_EN`.
- **With the macro defined:**
  - One extra byte follows the image; in CRC state `cfg_ready`=1.
  - CRC-8 parameters: polynomial 0x07, init 0x00, MSB-first per byte, no reflection, no final XOR, computed over all 354 image bytes.
  - Match → COMMIT.
  - Mismatch → IDLE with `cfg_err`=1; outputs unchanged and no `cfg_done` pulse.
  - `cfg_err` clears on the next `start` or on `rst`.
- **Without the macro:** no CRC state or logic, and `cfg_err` is tied to 0.

## Structure
- Package `fpga_cfg_pkg`:
  - state enum;
  - constants `IMG_BITS`, `IMG_BYTES`;
  - per-vector widths and base offsets (BRB_OFS=0, BSB_OFS=900, LB_OFS=2628, LIO_OFS=2708, RIO_OFS=2738, TIO_OFS=2768, BIO_OFS=2798).
- Sub-module `fpga_cfg_crc8`: clear, byte enable, 8-bit data in → registered CRC out. Instantiated only under `FPGA_CFG_CRC_EN`.

## Test plan
- **Reset:** hold `rst` 2 cycles mid-load (after 100 bytes) → all outputs 0, `cfg_busy`=0, and the next `start` loads cleanly from byte 0.
- **Full load:** 354 bytes with `cfg_valid` continuous.
  - Image: bit 0 = 1, bit 5 = 1, bottom-io bit 0 = 1 (byte 0 = 0x21, byte 349 bits 7:6 → bit 2798 set).
  - Expected: `brbselect[5]`=1, `brbselect[0]`=1, `bottomioselect[0]`=1, everything else 0, `cfg_done` exactly one cycle after the last accept.
- **Bubbles and atomicity:** `cfg_valid` toggled 1/0 every cycle with 0xFF bytes → 354 accepts in 708 cycles; outputs stay at the previous image until the commit edge, then become all-ones.
- **Abort:**
  - `abort` asserted together with `cfg_valid` on byte 200 → IDLE, byte not counted, outputs keep the old image, no `cfg_done`.
  - `start` during LOAD is ignored.
- **CRC (`FPGA_CFG_CRC_EN`):**
  - All-zero image + CRC byte 0x00 → commit.
  - Same image + CRC 0x01 → `cfg_err`=1, no `cfg_done`, outputs unchanged.
  - Next `start` clears `cfg_err`.
